// File: rtl/piso_shift.sv
// piso_shift: parallel-in serial-out shift register with a valid/ready load port.
//
// A word is captured from `in` on a rising edge where load_valid && load_ready,
// and is then streamed one bit per rising edge with shift_en high. When the final
// bit is consumed and a new word is offered on the same edge, the new word is
// captured at once, so back-to-back words stream with no gap.
//
// Parameters
//   N          word width in bits (N >= 2)
//   MSB_FIRST  0: bit 0 leaves first, 1: bit N-1 leaves first
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   in          parallel word, sampled only on an accepted load
//   load_valid  source offers a word
//   load_ready  block accepts a word this cycle (combinational on shift_en)
//   shift_en    advance one bit on this edge
//   sout        current serial bit (0 when idle)
//   sout_valid  sout carries a data bit
//   last        sout is the final bit of the current word
//   busy        a word is being shifted (same as sout_valid)
module piso_shift #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         shift_en,
  output logic         sout,
  output logic         sout_valid,
  output logic         last,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   shreg;
  logic [N-1:0]   shreg_next;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_next;
  logic           accept;

  // Move the word one place toward the output end, zero-filling behind it.
  function automatic logic [N-1:0] shift_toward_out(input logic [N-1:0] word);
    logic [N-1:0] res;
    if (MSB_FIRST) begin
      res = {word[N-2:0], 1'b0};
    end else begin
      res = {1'b0, word[N-1:1]};
    end
    return res;
  endfunction

  // Outputs decoded from the state registers; load_ready also looks at shift_en
  // so a new word can follow the final bit without an idle cycle.
  always_comb begin
    load_ready = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = rst;
      end
      SHIFT: begin
        sout       = MSB_FIRST ? shreg[N-1] : shreg[0];
        sout_valid = 1'b1;
        busy       = 1'b1;
        last       = (cnt == CNT_LAST);
        load_ready = rst && (cnt == CNT_LAST) && shift_en;
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

  assign accept = load_valid && load_ready;

  // Next-state logic: capture, advance, chain the next word, or drop back to idle.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          shreg_next = in;
          cnt_next   = CNT_ZERO;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (!shift_en) begin
          state_next = SHIFT;
        end else if (cnt != CNT_LAST) begin
          shreg_next = shift_toward_out(shreg);
          cnt_next   = cnt + CNT_ONE;
        end else if (accept) begin
          // Final bit consumed and a new word is waiting: no gap.
          shreg_next = in;
          cnt_next   = CNT_ZERO;
        end else begin
          state_next = IDLE;
          shreg_next = {N{1'b0}};
          cnt_next   = CNT_ZERO;
        end
      end
      default: begin
        state_next = IDLE;
        shreg_next = {N{1'b0}};
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // State registers; reset discards any partial word immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= {N{1'b0}};
      cnt   <= CNT_ZERO;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      cnt   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_piso_shift.sv
// Self-checking bench for piso_shift: one LSB-first and one MSB-first instance
// share the stimulus. A queue-of-pending-bits model predicts every output.
module tb_piso_shift;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in;
  logic         lv;
  logic         se;

  logic rdy_l, s_l, v_l, last_l, busy_l;
  logic rdy_m, s_m, v_m, last_m, busy_m;

  int checks = 0;
  int errors = 0;

  // model: bits still to be presented, head = bit on sout
  bit q_l[$];
  bit q_m[$];
  bit acc = 1'b0;

  piso_shift #(.N(N), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .in(in), .load_valid(lv), .load_ready(rdy_l),
    .shift_en(se), .sout(s_l), .sout_valid(v_l), .last(last_l), .busy(busy_l)
  );

  piso_shift #(.N(N), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in(in), .load_valid(lv), .load_ready(rdy_m),
    .shift_en(se), .sout(s_m), .sout_valid(v_m), .last(last_m), .busy(busy_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return rst && ((q_l.size() == 0) || (q_l.size() == 1 && se));
  endfunction

  // Model update on each edge, and immediate clear on reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_l.delete();
      q_m.delete();
      acc = 1'b0;
    end else begin
      acc = lv && model_ready();
      if (se && q_l.size() > 0) begin
        void'(q_l.pop_front());
        void'(q_m.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < N; i++) begin
          q_l.push_back(in[i]);
          q_m.push_back(in[N-1-i]);
        end
      end
    end
  end

  task automatic cmp(input string tag, input int sz, input bit head,
                     input logic s, input logic v, input logic l,
                     input logic b, input logic r);
    chk({tag, "_sout"},  s, (sz > 0) ? int'(head) : 0);
    chk({tag, "_valid"}, v, sz > 0);
    chk({tag, "_busy"},  b, sz > 0);
    chk({tag, "_last"},  l, sz == 1);
    chk({tag, "_ready"}, r, model_ready());
  endtask

  // Per-cycle compare, away from the active edge and after inputs settle.
  always @(negedge clk) begin
    #2;
    cmp("lsb", q_l.size(), (q_l.size() > 0) ? q_l[0] : 1'b0, s_l, v_l, last_l, busy_l, rdy_l);
    cmp("msb", q_m.size(), (q_m.size() > 0) ? q_m[0] : 1'b0, s_m, v_m, last_m, busy_m, rdy_m);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_l4;
    logic [3:0] exp_m4;
    logic [7:0] exp8;
    int pulses;
    int rst_hold;

    rst = 1'b0; in = '0; lv = 1'b0; se = 1'b0;
    @(negedge clk); #2;
    chk("reset_valid", v_l, 0);
    chk("reset_ready", rdy_l, 0);
    chk("reset_sout", s_l, 0);
    @(negedge clk); rst = 1'b1; #2;
    chk("release_ready", rdy_l, 1);

    // basic: 4'b1011, LSB 1,1,0,1 and MSB 1,0,1,1
    exp_l4 = 4'b1011; exp_m4 = 4'b1101;
    @(negedge clk); in = 4'b1011; lv = 1'b1; se = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); lv = 1'b0; in = 4'($urandom); #2;
      chk("basic_lsb_sout", s_l, exp_l4[i]);
      chk("basic_msb_sout", s_m, exp_m4[i]);
      chk("basic_last", last_l, i == 3);
      chk("basic_msb_last", last_m, i == 3);
    end
    @(negedge clk); #2;
    chk("basic_busy_end", busy_l, 0);
    chk("basic_ready_end", rdy_l, 1);

    // back-to-back: A then 5 -> 0,1,0,1,1,0,1,0
    exp8 = 8'b0101_1010; pulses = 0;
    @(negedge clk); in = 4'hA; lv = 1'b1; se = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) in = 4'h5;
      if (i == 4) lv = 1'b0;
      #2;
      chk("b2b_sout", s_l, exp8[i]);
      chk("b2b_valid", v_l, 1);
      chk("b2b_ready", rdy_l, (i == 3) || (i == 7));
      if (i < 7 && rdy_l) pulses++;
    end
    chk("b2b_ready_pulses", pulses, 1);

    // stall: 4'b0110, advance one cycle in three
    exp_l4 = 4'b0110;
    @(negedge clk); in = 4'b0110; lv = 1'b1; se = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk); lv = 1'b0; se = (j % 3 == 2); #2;
      chk("stall_sout", s_l, exp_l4[j/3]);
      chk("stall_last", last_l, (j / 3) == 3);
    end
    @(negedge clk); se = 1'b1; #2;
    chk("stall_idle", busy_l, 0);

    // busy rejection: 9 streams intact, F accepted only at its final edge
    exp8 = 8'hF9;
    @(negedge clk); in = 4'h9; lv = 1'b1; se = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) lv = 1'b0;
      if (i == 1) begin lv = 1'b1; in = 4'hF; end
      if (i == 4) lv = 1'b0;
      #2;
      chk("reject_sout", s_l, exp8[i]);
      chk("reject_ready", rdy_l, (i == 3) || (i == 7));
    end
    @(negedge clk); #2;

    // async reset mid-word, then 4'h3 -> 1,1,0,0
    @(negedge clk); in = 4'hF; lv = 1'b1; se = 1'b1;
    @(negedge clk); lv = 1'b0;
    @(negedge clk);
    @(posedge clk); #2; rst = 1'b0; lv = 1'b1; #1;
    chk("arst_sout", s_l, 0);
    chk("arst_valid", v_l, 0);
    chk("arst_busy", busy_l, 0);
    chk("arst_last", last_l, 0);
    chk("arst_ready", rdy_l, 0);
    @(negedge clk); #2;
    chk("arst_ready_hold", rdy_l, 0);
    @(negedge clk); rst = 1'b1; in = 4'h3; lv = 1'b1; se = 1'b1; #1;
    chk("arst_release_ready", rdy_l, 1);
    exp_l4 = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); lv = 1'b0; #2;
      chk("arst_next_sout", s_l, exp_l4[i]);
    end

    // randomized phase, checked by the compare process
    rst_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        rst_hold = 2;
      end
      if (!(lv && !acc)) begin
        lv = ($urandom_range(0, 3) != 0);
        in = 4'($urandom);
      end
      se = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk); #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_shift.md
# piso_shift

Parameterised parallel-in serial-out shift register with a valid/ready load port and a per-bit shift enable. It is the transmit-side companion to the team's parallel and serial-in register library. A word is captured from a parallel bus and then streamed one bit per enabled clock edge. Back-to-back words stream with no gap, so the block can feed serial links, SIPO-based receivers, or bit-serial datapaths.

## Interface
- N, default 4: word width in bits; legal range N >= 2.
- MSB_FIRST, default 0: 0 shifts bit 0 out first; 1 shifts bit N-1 out first.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous and active-low; clears all state immediately when low.
- in  input  N  parallel word; sampled only on an accepted load.
- load_valid  input  1  source has a word on in.
- load_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  bit advance enable (tie high for one bit per cycle).
- sout  output  1  current serial bit.
- sout_valid  output  1  sout carries a data bit.
- last  output  1  sout is the final bit of the current word.
- busy  output  1  a word is being shifted (equals sout_valid).

## Operation
- State: an FSM with IDLE and SHIFT, an N-bit shift register, and a bit counter cnt of width $clog2(N).
- Load handshake: a word is accepted on a rising edge where load_valid && load_ready.
  - While load_valid is high and load_ready is low, the source holds in stable.
  - load_ready is combinational: 1 in IDLE; in SHIFT it is 1 only when cnt == N-1 && shift_en; it is 0 while rst is low.
- IDLE:
  - sout = 0, sout_valid = 0, last = 0, busy = 0.
  - shift_en is ignored.
  - An accepted load captures in, sets cnt = 0, and moves to SHIFT.
- SHIFT:
  - sout = shreg[0] when MSB_FIRST = 0, or shreg[N-1] when MSB_FIRST = 1.
  - sout_valid = 1, busy = 1, last = (cnt == N-1).
- Each edge with shift_en = 1 and cnt < N-1:
  - The register shifts toward the output end (right for LSB-first, left for MSB-first), zero fill.
  - cnt increments.
- Edge with shift_en = 1 and cnt == N-1:
  - If load_valid is also 1 (so load_ready = 1), the new word is captured, cnt = 0, and the FSM stays in SHIFT. No idle bit is inserted.
  - Otherwise the FSM returns to IDLE and the register clears to 0.
- Edge with shift_en = 0 in SHIFT: no state change; sout holds.
- load_valid in SHIFT before the final enabled edge: not accepted; the current word is unaffected.
- Reset (rst low, any time, including mid-word):
  - FSM goes to IDLE; shreg = 0, cnt = 0; sout = 0, sout_valid = 0, last = 0, busy = 0, load_ready = 0.
  - Any partial word is discarded.
  - After rst rises, load_ready = 1 immediately (IDLE).

## Timing
- Load latency: if a word is accepted at edge k, its first bit is on sout, with sout_valid = 1, from just after edge k.
- Bit duration: each bit is held until the next edge with shift_en = 1.
- Word duration: with shift_en tied high, a word occupies exactly N cycles. Continuous load_valid gives a gapless stream of N bits per word.
- last is high for the whole period the final bit is presented. It falls after the enabled edge that consumes that bit.
- No combinational path from in to any output. Only load_ready depends combinationally on shift_en.

## Test plan
- Basic LSB-first: N=4, MSB_FIRST=0, load 4'b1011 with shift_en=1.
  - Required: sout = 1,1,0,1 on 4 consecutive cycles; last high on cycle 4 only; busy falls and load_ready = 1 on cycle 5.
- MSB-first: N=4, MSB_FIRST=1, load 4'b1011.
  - Required: sout = 1,0,1,1; last on the 4th bit.
- Back-to-back: load_valid held high with 4'hA, then 4'h5, LSB-first, shift_en=1.
  - Required: 8 contiguous valid bits 0,1,0,1,1,0,1,0; sout_valid never drops; load_ready pulses exactly once, on the 4th bit.
- Stall: load 4'b0110 with shift_en high one cycle in three.
  - Required: each bit is held 3 cycles; sequence 0,1,1,0; last held 3 cycles.
- Busy rejection: load 4'h9, then assert load_valid with 4'hF during bit 1.
  - Required: sout still 1,0,0,1; 4'hF is accepted only at the final enabled edge.
- Async reset mid-word: load 4'hF, drive rst low between clock edges after 2 bits.
  - Required: sout, sout_valid, busy and last go to 0 without waiting for a clock edge; load_ready is 0 while rst is low and 1 after release; the next load of 4'h3 streams 1,1,0,0 cleanly.
